// File: rtl/enet_rx_deframer.sv
// enet_rx_deframer: packs 2/4/8-bit receive symbols into bytes, strips the
// preamble and SFD, and streams payload bytes with sop/eop/err markers and
// saturating good/bad frame counters.
module enet_rx_deframer #(
  parameter int MIN_PRE = 2,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mii_select,
  input  logic             rmii_select,
  input  logic [7:0]       rxd,
  input  logic             rx_dv,
  input  logic             rx_er,
  output logic             out_valid,
  output logic [7:0]       out_data,
  output logic             out_sop,
  output logic             out_eop,
  output logic             out_err,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [1:0]       dbg_state
);
  // Output handshake: out_valid is a single-cycle strobe with no ready/backpressure;
  // out_data/out_sop/out_eop/out_err are meaningful only while out_valid=1.

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_PRE = 2'd1, S_DATA = 2'd2, S_DROP = 2'd3} state_e;

  // Lane width codes: 8-bit, 4-bit, 2-bit symbols.
  localparam logic [1:0]       M_W8    = 2'd0;
  localparam logic [1:0]       M_W4    = 2'd1;
  localparam logic [1:0]       M_W2    = 2'd2;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [1:0]       mode_q, mode_d, beat_q, beat_d;
  logic [7:0]       asm_q, asm_d, hold_q, hold_d, odata_q, odata_d;
  logic [2:0]       pre_q, pre_d;
  logic             hold_vld_q, hold_vld_d, first_q, first_d, sticky_q, sticky_d;
  logic             ov_q, ov_d, sop_q, sop_d, eop_q, eop_d, oerr_q, oerr_d;
  logic [CNT_W-1:0] fcnt_q, fcnt_d, ecnt_q, ecnt_d;
  logic             frame_inc, err_inc;

  logic [1:0] live_mode, cur_mode, cur_beat, last_beat;
  logic [7:0] cur_asm, sym, byte_val;
  logic [2:0] cur_pre, shamt;
  logic       byte_done;

  // Decode the live interface select into a lane width code.
  always_comb begin
    case ({mii_select, rmii_select})
      2'b10:   live_mode = M_W4;
      2'b11:   live_mode = M_W2;
      default: live_mode = M_W8;
    endcase
  end

  // Lane extraction and LSB-first byte assembly; IDLE behaves as a fresh frame.
  always_comb begin
    cur_mode = (state_q == S_IDLE) ? live_mode : mode_q;
    cur_beat = (state_q == S_IDLE) ? 2'd0 : beat_q;
    cur_asm  = (state_q == S_IDLE) ? 8'd0 : asm_q;
    cur_pre  = (state_q == S_IDLE) ? 3'd0 : pre_q;
    case (cur_mode)
      M_W4: begin
        sym       = {4'd0, rxd[3:0]};
        last_beat = 2'd1;
        shamt     = {cur_beat[0], 2'b00};
      end
      M_W2: begin
        sym       = {6'd0, rxd[1:0]};
        last_beat = 2'd3;
        shamt     = {cur_beat, 1'b0};
      end
      default: begin
        sym       = rxd;
        last_beat = 2'd0;
        shamt     = 3'd0;
      end
    endcase
    byte_val  = cur_asm | (sym << shamt);
    byte_done = rx_dv && (cur_beat == last_beat);
  end

  // Frame FSM: preamble/SFD check, one-byte hold pipeline, end-of-frame flush, counters.
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    beat_d     = beat_q;
    asm_d      = asm_q;
    pre_d      = pre_q;
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    first_d    = first_q;
    sticky_d   = sticky_q;
    odata_d    = odata_q;
    ov_d       = 1'b0;
    sop_d      = 1'b0;
    eop_d      = 1'b0;
    oerr_d     = 1'b0;
    frame_inc  = 1'b0;
    err_inc    = 1'b0;

    if (rx_dv) begin
      if (byte_done) begin
        beat_d = 2'd0;
        asm_d  = 8'd0;
      end else begin
        beat_d = cur_beat + 2'd1;
        asm_d  = byte_val;
      end
    end

    case (state_q)
      S_IDLE, S_PRE: begin
        if (state_q == S_IDLE) mode_d = live_mode;
        pre_d = cur_pre;
        if (!rx_dv) begin
          state_d = S_IDLE;
        end else if (rx_er) begin
          state_d = S_DROP;
          err_inc = 1'b1;
        end else begin
          state_d = S_PRE;
          if (byte_done) begin
            if (byte_val == 8'h55) begin
              if (cur_pre != 3'd7) pre_d = cur_pre + 3'd1;
            end else if (byte_val == 8'hD5 && int'(cur_pre) >= MIN_PRE) begin
              state_d    = S_DATA;
              hold_vld_d = 1'b0;
              first_d    = 1'b1;
              sticky_d   = 1'b0;
            end else begin
              state_d = S_DROP;
              err_inc = 1'b1;
            end
          end
        end
      end
      S_DATA: begin
        if (rx_dv) begin
          if (rx_er) sticky_d = 1'b1;
          if (byte_done) begin
            if (hold_vld_q) begin
              ov_d    = 1'b1;
              odata_d = hold_q;
              sop_d   = first_q;
              first_d = 1'b0;
            end
            hold_d     = byte_val;
            hold_vld_d = 1'b1;
          end
        end else begin
          state_d    = S_IDLE;
          hold_vld_d = 1'b0;
          if (hold_vld_q) begin
            ov_d    = 1'b1;
            odata_d = hold_q;
            sop_d   = first_q;
            eop_d   = 1'b1;
            oerr_d  = sticky_q || (beat_q != 2'd0);
            if (sticky_q || (beat_q != 2'd0)) err_inc = 1'b1;
            else frame_inc = 1'b1;
          end else begin
            err_inc = 1'b1;
          end
        end
      end
      S_DROP: begin
        if (!rx_dv) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    fcnt_d = (frame_inc && fcnt_q != CNT_MAX) ? fcnt_q + CNT_ONE : fcnt_q;
    ecnt_d = (err_inc && ecnt_q != CNT_MAX) ? ecnt_q + CNT_ONE : ecnt_q;
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      mode_q     <= M_W8;
      beat_q     <= 2'd0;
      asm_q      <= 8'd0;
      pre_q      <= 3'd0;
      hold_q     <= 8'd0;
      hold_vld_q <= 1'b0;
      first_q    <= 1'b0;
      sticky_q   <= 1'b0;
      odata_q    <= 8'd0;
      ov_q       <= 1'b0;
      sop_q      <= 1'b0;
      eop_q      <= 1'b0;
      oerr_q     <= 1'b0;
      fcnt_q     <= '0;
      ecnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      beat_q     <= beat_d;
      asm_q      <= asm_d;
      pre_q      <= pre_d;
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
      first_q    <= first_d;
      sticky_q   <= sticky_d;
      odata_q    <= odata_d;
      ov_q       <= ov_d;
      sop_q      <= sop_d;
      eop_q      <= eop_d;
      oerr_q     <= oerr_d;
      fcnt_q     <= fcnt_d;
      ecnt_q     <= ecnt_d;
    end
  end

  assign out_valid = ov_q;
  assign out_data  = odata_q;
  assign out_sop   = sop_q;
  assign out_eop   = eop_q;
  assign out_err   = oerr_q;
  assign frame_cnt = fcnt_q;
  assign err_cnt   = ecnt_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_enet_rx_deframer.sv
// Bench for enet_rx_deframer: directed frames plus randomized frames, with a
// byte-level frame model feeding an expected queue.
module tb_enet_rx_deframer;
  localparam int MIN_PRE = 2;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst, mii_select, rmii_select, rx_dv, rx_er;
  logic [7:0]       rxd, out_data;
  logic             out_valid, out_sop, out_eop, out_err;
  logic [CNT_W-1:0] frame_cnt, err_cnt;
  logic [1:0]       dbg_state;

  logic [10:0] exp_q[$];   // {sop, eop, err, data}
  logic [7:0]  frm_q[$];   // line bytes of the frame being sent
  logic [10:0] mon_e;
  int total = 0;
  int bad = 0;
  int exp_frames = 0;
  int exp_errs = 0;
  int cyc = 0;
  int eop_cyc = -1;

  enet_rx_deframer #(.MIN_PRE(MIN_PRE), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .mii_select(mii_select), .rmii_select(rmii_select),
    .rxd(rxd), .rx_dv(rx_dv), .rx_er(rx_er),
    .out_valid(out_valid), .out_data(out_data), .out_sop(out_sop),
    .out_eop(out_eop), .out_err(out_err),
    .frame_cnt(frame_cnt), .err_cnt(err_cnt), .dbg_state(dbg_state)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int sat(input int n);
    return (n > CNT_MAX) ? CNT_MAX : n;
  endfunction

  // scoreboard: every strobe must match the head of the expected queue
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_byte", 32'(out_valid), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("byte", {21'd0, out_sop, out_eop, out_err, out_data}, {21'd0, mon_e});
      end
      if (out_eop === 1'b1) eop_cyc = cyc;
    end
  end

  // Byte-level frame model: preamble/SFD rules, then payload with markers.
  task automatic model_frame(input int w, input int partial, input int er_beat, output bit has_eop);
    int bpb, nbytes, er_byte, pre, sfd_at;
    logic s, e, r, err;
    bpb = 8 / w;
    nbytes = frm_q.size();
    er_byte = (er_beat >= 0) ? er_beat / bpb : -1;
    pre = 0;
    sfd_at = -1;
    has_eop = 0;
    for (int i = 0; i <= nbytes; i++) begin
      if (er_byte == i) begin exp_errs++; return; end
      if (i == nbytes) return;
      if (frm_q[i] == 8'h55) pre = (pre < 7) ? pre + 1 : 7;
      else if (frm_q[i] == 8'hD5 && pre >= MIN_PRE) begin sfd_at = i; break; end
      else begin exp_errs++; return; end
    end
    if (sfd_at == nbytes - 1) begin exp_errs++; return; end
    err = (er_byte > sfd_at) || (partial > 0);
    for (int j = sfd_at + 1; j < nbytes; j++) begin
      s = (j == sfd_at + 1);
      e = (j == nbytes - 1);
      r = e & err;
      exp_q.push_back({s, e, r, frm_q[j]});
    end
    has_eop = 1;
    if (err) exp_errs++; else exp_frames++;
  endtask

  task automatic drive_beat(input logic [7:0] d, input logic er);
    rx_dv = 1'b1;
    rx_er = er;
    rxd = d;
    @(posedge clk); #1;
  endtask

  task automatic check_counts();
    check("frame_cnt", 32'(frame_cnt), 32'(sat(exp_frames)));
    check("err_cnt", 32'(err_cnt), 32'(sat(exp_errs)));
  endtask

  // Send frm_q on the lane of sel, then partial extra beats; er_beat<0 = no rx_er.
  task automatic send_frame(input logic [1:0] sel, input int partial, input int er_beat, input bit tight);
    int w, bpb, nb;
    bit has_eop;
    logic [7:0] mask, sym;
    w = (sel == 2'b10) ? 4 : (sel == 2'b11) ? 2 : 8;
    bpb = 8 / w;
    mask = 8'((1 << w) - 1);
    {mii_select, rmii_select} = sel;
    model_frame(w, partial, er_beat, has_eop);
    nb = 0;
    for (int i = 0; i < frm_q.size(); i++) begin
      for (int k = 0; k < bpb; k++) begin
        sym = (frm_q[i] >> (k * w)) & mask;
        drive_beat((8'($urandom) & ~mask) | sym, nb == er_beat);
        nb++;
        if (nb == 1) {mii_select, rmii_select} = 2'($urandom);
      end
    end
    for (int p = 0; p < partial; p++) begin
      drive_beat(8'($urandom), nb == er_beat);
      nb++;
    end
    rx_dv = 1'b0;
    rx_er = 1'b0;
    rxd = 8'($urandom);
    @(posedge clk); #1;
    if (!tight) begin
      @(negedge clk); #1;
      if (has_eop) check("eop_latency", 32'(eop_cyc), 32'(cyc));
      check_counts();
      check("q_drain", 32'(exp_q.size()), 32'd0);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
  endtask

  task automatic build_std(input int npre, input logic [7:0] first, input int npay);
    frm_q.delete();
    for (int i = 0; i < npre; i++) frm_q.push_back(8'h55);
    frm_q.push_back(8'hD5);
    for (int i = 0; i < npay; i++) frm_q.push_back(first + 8'(i));
  endtask

  initial begin
    rst = 1'b1; rx_dv = 1'b0; rx_er = 1'b0; rxd = 8'd0;
    mii_select = 1'b0; rmii_select = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk); #1;
    check("rst_outs", {27'd0, out_valid, out_sop, out_eop, out_err, 1'b0}, 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    check_counts();

    // GMII 64-byte frame
    build_std(7, 8'h01, 64);
    send_frame(2'b00, 0, -1, 0);
    check("t1_frames", 32'(frame_cnt), 32'd1);
    // MII, same frame
    send_frame(2'b10, 0, -1, 0);
    check("t2_frames", 32'(frame_cnt), 32'd2);
    // RMII, rx_er on payload beat 40
    send_frame(2'b11, 0, 8 * 4 + 40, 0);
    check("t3_errs", 32'(err_cnt), 32'd1);
    // short preamble then a good frame
    build_std(1, 8'h00, 0);
    send_frame(2'b00, 0, -1, 0);
    check("t4_errs", 32'(err_cnt), 32'd2);
    build_std(2, 8'hA0, 5);
    send_frame(2'b00, 0, -1, 0);
    check("t4_frames", 32'(frame_cnt), 32'd3);
    // MII lone trailing nibble, then SFD with immediate dv drop
    build_std(7, 8'h30, 8);
    send_frame(2'b10, 1, -1, 0);
    build_std(7, 8'h00, 0);
    send_frame(2'b10, 0, -1, 0);
    check("t5_errs", 32'(err_cnt), 32'd4);
    // single-byte frame, then back-to-back with one idle cycle
    build_std(3, 8'h77, 1);
    send_frame(2'b01, 0, -1, 1);
    send_frame(2'b00, 0, -1, 0);

    // reset mid-payload: payload bytes 0..3 already out, nothing else
    build_std(7, 8'h10, 16);
    {mii_select, rmii_select} = 2'b00;
    exp_q.push_back({3'b100, 8'h10});
    exp_q.push_back({3'b000, 8'h11});
    exp_q.push_back({3'b000, 8'h12});
    exp_q.push_back({3'b000, 8'h13});
    for (int i = 0; i < 13; i++) drive_beat(frm_q[i], 1'b0);
    rst = 1'b1; rx_dv = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_frames = 0; exp_errs = 0;
    @(negedge clk); #1;
    check("rst_mid_valid", 32'(out_valid), 32'd0);
    check("rst_mid_eop", 32'(out_eop), 32'd0);
    check("rst_mid_q", 32'(exp_q.size()), 32'd0);
    check_counts();
    build_std(4, 8'hC0, 6);
    send_frame(2'b11, 0, -1, 0);
    check("rst_next_frames", 32'(frame_cnt), 32'd1);

    // randomized frames
    for (int f = 0; f < 150; f++) begin
      logic [1:0] sel;
      int pl, np, part, er, bpb;
      sel = 2'($urandom);
      bpb = (sel == 2'b10) ? 2 : (sel == 2'b11) ? 4 : 1;
      frm_q.delete();
      pl = $urandom_range(0, 8);
      for (int i = 0; i < pl; i++)
        frm_q.push_back(($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'h55);
      if ($urandom_range(0, 19) != 0) frm_q.push_back(8'hD5);
      np = $urandom_range(0, 12);
      for (int i = 0; i < np; i++) frm_q.push_back(8'($urandom));
      if (frm_q.size() == 0) frm_q.push_back(8'hD5);
      part = (bpb > 1 && $urandom_range(0, 4) == 0) ? $urandom_range(1, bpb - 1) : 0;
      er = ($urandom_range(0, 6) == 0) ? $urandom_range(0, frm_q.size() * bpb + part - 1) : -1;
      send_frame(sel, part, er, (f != 149) && ($urandom_range(0, 3) == 0));
    end

    check("final_q", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
